graph_id_tx: RTL and testbench
==============================

Name: graph_id_tx

Overview:
- Transmitter that feeds the contact-graph block with its stream of node IDs.
- Buffers IDs from an upstream source in a small FIFO and range-checks each one against POPSIZE.
- Issues each ID with a one-cycle data_rdy strobe, then waits for the graph's data_vld/num_edges reply before sending the next ID.
- Sits between the ID source (sensor or host interface) and the graph module.

Parameters:
- POPSIZE, 100: number of valid node IDs; legal IDs are 0..POPSIZE-1.
- DATA_WIDTH, 8: width of num_edges, edges_out and drop_cnt.
- ID_WIDTH, 11: width of every ID bus.
- FIFO_DEPTH, 8: input buffer entries; must be a power of 2 and at least 2.
- TIMEOUT, 16: maximum cycles in WAIT before the block gives up on a reply.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_id  in  ID_WIDTH  upstream ID.
- in_valid  in  1  upstream ID valid.
- in_ready  out  1  buffer can accept an ID.
- ID_out  out  ID_WIDTH  ID presented to the graph.
- data_rdy  out  1  one-cycle issue strobe to the graph.
- data_vld  in  1  graph reply valid.
- num_edges  in  DATA_WIDTH  graph edge count that accompanies data_vld.
- edges_out  out  DATA_WIDTH  last latched edge count.
- edges_vld  out  1  one-cycle pulse when edges_out updates.
- busy  out  1  state is not IDLE, or the FIFO is not empty.
- drop_cnt  out  DATA_WIDTH  number of out-of-range IDs rejected; saturates.
- timeout_err  out  1  sticky flag: a reply timed out.

Behaviour:
- Reset: all of the following clear asynchronously to 0 / empty:
  - outputs ID_out, data_rdy, edges_out, edges_vld, drop_cnt, timeout_err, busy;
  - FIFO pointers and count;
  - timeout counter;
  - state returns to IDLE.
- Reset mid-operation discards all buffered IDs and any pending reply.
- Input side:
  - in_ready = !fifo_full, combinational.
  - Accept when in_valid && in_ready.
  - An accepted in_id >= POPSIZE is not written to the FIFO; drop_cnt increments and holds at 2^DATA_WIDTH-1.
  - When full, in_ready=0 even if a pop happens in the same cycle; this is deliberate and keeps the logic simple.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if the FIFO is not empty, pop the head into ID_out and go to ISSUE. data_vld is ignored in IDLE.
  - ISSUE: data_rdy=1 for exactly this one cycle; ID_out is stable. Clear the timeout counter. Go to WAIT.
  - WAIT: ID_out is held.
    - If data_vld: edges_out <= num_edges, edges_vld=1 on the next cycle, go to IDLE.
    - Else the counter increments. When it reaches TIMEOUT-1 without data_vld, set timeout_err, go to IDLE, and leave edges_out unchanged.
    - If data_vld and timeout land in the same cycle, data_vld wins and timeout_err is not set.
- Latency:
  - ID pushed into an empty, idle block: data_rdy is high 2 cycles after the push edge (push, then IDLE pop, then ISSUE).
  - Back-to-back issues are at least 3 cycles apart.
- busy is registered and reflects the state and FIFO count of the next cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is one bit wider.

Optional Feature:
- Macro: GRAPH_TX_DEDUP_EN.
- Defined: in IDLE, a popped ID equal to the last issued ID (valid only after at least one issue since reset) is discarded.
  - No data_rdy is raised and the state stays IDLE; the next pop may happen on the following cycle.
  - The last-ID register clears on reset.
- Undefined: every in-range ID is issued, including repeats.

Decomposition:
- graph_pkg holds:
  - the typedef enum tx_state_t {IDLE, ISSUE, WAIT};
  - the default constants POPSIZE, ID_WIDTH, DATA_WIDTH.
- One sub-module, graph_id_fifo: a parameterised synchronous FIFO.
  - Ports: clk, rst, push, din, pop, dout, full, empty.
  - Output is first-word-fall-through.

Test Plan:
- Reset, then push ID 0x001; graph model replies data_vld with num_edges=0 five cycles after data_rdy.
  - Expect ID_out=0x001 and a 1-cycle data_rdy exactly 2 cycles after the push.
  - Expect edges_out=0 and edges_vld pulsed once.
- Push 0x001, 0x002, 0x003 on consecutive cycles.
  - Expect three data_rdy pulses in order, each only after the previous reply.
  - Expect replies num_edges=1,2,3 to appear on edges_out in order.
- Push 0x064 (100) and 0x7FF.
  - Expect no data_rdy, drop_cnt=2, FIFO empty.
  - Then push 300 further invalid IDs; expect drop_cnt saturated at 255.
- Push 9 IDs with the graph model never replying.
  - Expect in_ready=0 once 8 are buffered.
  - Expect timeout_err set TIMEOUT cycles after the first data_rdy, and the next ID issued afterwards.
- Assert rst while in WAIT with 4 IDs buffered.
  - Expect all outputs at 0 immediately, and no data_rdy after release until new pushes.
- With GRAPH_TX_DEDUP_EN defined, push 0x002 then 0x002.
  - Expect one data_rdy only.
  - Without the macro, expect two.

Source files
------------

// File: rtl/graph_pkg.sv
// graph_pkg: shared types and default constants for the graph ID transmitter.
//   tx_state_t : transmitter FSM states (IDLE, ISSUE, WAIT)
//   POPSIZE, ID_WIDTH, DATA_WIDTH, FIFO_DEPTH, TIMEOUT : default parameters
package graph_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } tx_state_t;

  localparam int POPSIZE    = 100;
  localparam int ID_WIDTH   = 11;
  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 16;

endpackage

// File: rtl/graph_id_fifo.sv
// graph_id_fifo: parameterised synchronous first-word-fall-through FIFO.
//   clk   : clock (rising edge)
//   rst   : asynchronous active-high reset, empties the FIFO
//   push  : write din (ignored while full)
//   din   : write data
//   pop   : consume the head entry (ignored while empty)
//   dout  : head entry, valid whenever empty is low
//   full  : DEPTH entries stored
//   empty : no entries stored
module graph_id_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Fall-through read: the head is visible without a pop request.
  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/graph_id_tx.sv
// graph_id_tx: buffers node IDs from an upstream source, drops IDs outside
// 0..POPSIZE-1, and hands each remaining ID to the contact-graph block with a
// one-cycle data_rdy strobe, waiting for the data_vld/num_edges reply (or a
// timeout) before issuing the next one.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_id/in_valid       : upstream ID and valid
//   in_ready             : buffer can accept (low whenever the FIFO is full)
//   ID_out, data_rdy     : ID and issue strobe towards the graph
//   data_vld, num_edges  : graph reply
//   edges_out, edges_vld : last latched edge count and its update pulse
//   busy                 : FSM not idle or IDs still buffered (registered)
//   drop_cnt             : saturating count of rejected out-of-range IDs
//   timeout_err          : sticky, set when a reply never arrived
//
// Build option: GRAPH_TX_DEDUP_EN -- when defined, an ID equal to the last
// issued one is discarded in IDLE instead of being issued again.
module graph_id_tx #(
  parameter int POPSIZE    = graph_pkg::POPSIZE,
  parameter int DATA_WIDTH = graph_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = graph_pkg::ID_WIDTH,
  parameter int FIFO_DEPTH = graph_pkg::FIFO_DEPTH,
  parameter int TIMEOUT    = graph_pkg::TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ID_WIDTH-1:0]   ID_out,
  output logic                  data_rdy,
  input  logic                  data_vld,
  input  logic [DATA_WIDTH-1:0] num_edges,
  output logic [DATA_WIDTH-1:0] edges_out,
  output logic                  edges_vld,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] drop_cnt,
  output logic                  timeout_err
);

  import graph_pkg::tx_state_t;
  import graph_pkg::IDLE;
  import graph_pkg::ISSUE;
  import graph_pkg::WAIT;

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = AW + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [ID_WIDTH:0]   POP_LIM  = (ID_WIDTH + 1)'(POPSIZE);

  tx_state_t             r_state;
  tx_state_t             w_state_next;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ID_WIDTH-1:0]   w_fifo_dout;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_reply;
  logic                  w_timeout;
  logic                  w_dedup_hit;
  logic [OCC_W-1:0]      w_occ_next;

  logic [OCC_W-1:0]      r_occ;
  logic [TW-1:0]         r_tmo_cnt;
  logic [ID_WIDTH-1:0]   r_id_out;
  logic                  r_data_rdy;
  logic [DATA_WIDTH-1:0] r_edges_out;
  logic                  r_edges_vld;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_drop_cnt;
  logic                  r_timeout_err;

  // ---------------- input side ----------------
  // in_ready ignores a same-cycle pop on purpose: full simply means "not now".
  assign in_ready   = !w_fifo_full;
  assign w_accept   = in_valid && in_ready;
  assign w_in_range = ({1'b0, in_id} < POP_LIM);
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;

  graph_id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (in_id),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // ---------------- optional duplicate suppression ----------------
`ifdef GRAPH_TX_DEDUP_EN
  // ID_out always holds the last issued ID; this flag says it is meaningful.
  logic r_last_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_vld <= 1'b0;
    end else if (w_issue) begin
      r_last_vld <= 1'b1;
    end
  end

  assign w_dedup_hit = r_last_vld && (w_fifo_dout == r_id_out);
`else
  assign w_dedup_hit = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_reply      = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          // A duplicate is still popped, just not issued.
          w_pop = 1'b1;
          if (!w_dedup_hit) begin
            w_issue      = 1'b1;
            w_state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_state_next = WAIT;
      end
      WAIT: begin
        // A reply landing on the last permitted cycle beats the timeout.
        if (data_vld) begin
          w_reply      = 1'b1;
          w_state_next = IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Occupancy shadow of the FIFO so busy can be registered from next-cycle state.
  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + OCC_W'(1);
      2'b01:   w_occ_next = r_occ - OCC_W'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  // ---------------- registered outputs and counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ         <= '0;
      r_tmo_cnt     <= '0;
      r_id_out      <= '0;
      r_data_rdy    <= 1'b0;
      r_edges_out   <= '0;
      r_edges_vld   <= 1'b0;
      r_busy        <= 1'b0;
      r_drop_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_occ       <= w_occ_next;
      r_busy      <= (w_state_next != IDLE) || (w_occ_next != '0);
      // data_rdy is high exactly while the FSM sits in ISSUE.
      r_data_rdy  <= w_issue;
      r_edges_vld <= w_reply;

      if (w_issue) begin
        r_id_out <= w_fifo_dout;
      end
      if (w_reply) begin
        r_edges_out <= num_edges;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end

      if (r_state == ISSUE) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == WAIT) && !data_vld && (r_tmo_cnt != TMO_LAST)) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end

      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DATA_WIDTH'(1);
      end
    end
  end

  assign ID_out      = r_id_out;
  assign data_rdy    = r_data_rdy;
  assign edges_out   = r_edges_out;
  assign edges_vld   = r_edges_vld;
  assign busy        = r_busy;
  assign drop_cnt    = r_drop_cnt;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_graph_id_tx.sv
`timescale 1ns/1ps
// tb_graph_id_tx: scoreboard bench for graph_id_tx. Stimulus pushes the IDs it
// expects to see issued and the edge counts it expects back; a negedge
// monitor, which also plays the graph (reply 5 cycles after data_rdy),
// pops and compares whenever data_rdy or edges_vld is seen.
module tb_graph_id_tx;

  localparam int TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] in_id;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] ID_out;
  logic        data_rdy;
  logic        data_vld;
  logic [7:0]  num_edges;
  logic [7:0]  edges_out;
  logic        edges_vld;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  graph_id_tx dut (
    .clk         (clk),
    .rst         (rst),
    .in_id       (in_id),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ID_out      (ID_out),
    .data_rdy    (data_rdy),
    .data_vld    (data_vld),
    .num_edges   (num_edges),
    .edges_out   (edges_out),
    .edges_vld   (edges_vld),
    .busy        (busy),
    .drop_cnt    (drop_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rdy = 0;
  int n_edges = 0;
  int last_rdy_cyc = -100;
  int last_push_cyc = 0;
  int first_tmo_cyc = -1;
  int reply_timer = 0;
  bit reply_en = 1'b0;
  logic [10:0] exp_id_q[$];
  logic [7:0]  exp_edges_q[$];
  logic [7:0]  rep_q[$];
  int          rdy_cyc_q[$];
  logic [10:0] mon_id;
  logic [7:0]  mon_edges;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Graph model + scoreboard monitor, all on the falling edge.
  initial begin
    data_vld  = 1'b0;
    num_edges = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (data_vld) begin
        data_vld  = 1'b0;
        num_edges = 8'h00;
      end
      if (reply_timer > 0) begin
        reply_timer--;
        if (reply_timer == 0) begin
          data_vld  = 1'b1;
          num_edges = (rep_q.size() > 0) ? rep_q.pop_front() : 8'hEE;
        end
      end
      if (!rst) begin
        if (data_rdy) begin
          n_rdy++;
          checks++;
          if (exp_id_q.size() == 0) begin
            errors++;
            $display("FAIL issue_extra: ID_out=0x%0h but no issue expected", ID_out);
          end else begin
            mon_id = exp_id_q.pop_front();
            if (ID_out !== mon_id) begin
              errors++;
              $display("FAIL issue_id: got 0x%0h expected 0x%0h", ID_out, mon_id);
            end else begin
              $display("ok   issue_id = 0x%0h at cycle %0d", ID_out, cyc);
            end
          end
          chk("issue_spacing_ge3", ((cyc - last_rdy_cyc) >= 3), 1);
          if (reply_en) begin
            chk("reply_before_next_issue", reply_timer, 0);
            reply_timer = 5;
          end
          rdy_cyc_q.push_back(cyc);
          last_rdy_cyc = cyc;
        end
        if (edges_vld) begin
          n_edges++;
          checks++;
          if (exp_edges_q.size() == 0) begin
            errors++;
            $display("FAIL edges_extra: edges_out=0x%0h but no update expected", edges_out);
          end else begin
            mon_edges = exp_edges_q.pop_front();
            if (edges_out !== mon_edges) begin
              errors++;
              $display("FAIL edges_out: got 0x%0h expected 0x%0h", edges_out, mon_edges);
            end else begin
              $display("ok   edges_out = 0x%0h at cycle %0d", edges_out, cyc);
            end
          end
        end
        if (timeout_err && (first_tmo_cyc < 0)) begin
          first_tmo_cyc = cyc;
        end
      end
    end
  end

  // Present one ID for exactly one cycle; entered and left at posedge+1.
  task automatic send(input logic [10:0] id);
    in_valid = 1'b1;
    in_id    = id;
    @(negedge clk);
    last_push_cyc = cyc;
    chk("in_ready_on_push", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_rdy(input int target, input int budget, input string name);
    int k;
    k = 0;
    while ((n_rdy < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk(name, n_rdy, target);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_id    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ID_out", ID_out, 0);
    chk("rst_data_rdy", data_rdy, 0);
    chk("rst_edges_out", edges_out, 0);
    chk("rst_edges_vld", edges_vld, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    idle_cycles(1);

    // T1: single ID, reply 0 after five cycles.
    reply_en = 1'b1;
    exp_id_q.push_back(11'h001); rep_q.push_back(8'd0); exp_edges_q.push_back(8'd0);
    send(11'h001);
    wait_rdy(1, 20, "t1_issued");
    chk("t1_rdy_latency", last_rdy_cyc - last_push_cyc, 2);
    idle_cycles(10);
    chk("t1_edges_vld_pulses", n_edges, 1);
    chk("t1_busy_done", busy, 0);

    // T2: three back-to-back IDs, replies 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      exp_id_q.push_back(11'(i)); rep_q.push_back(8'(i)); exp_edges_q.push_back(8'(i));
    end
    send(11'h001); send(11'h002); send(11'h003);
    wait_rdy(4, 60, "t2_issued");
    idle_cycles(12);
    chk("t2_edges_vld_pulses", n_edges, 4);
    chk("t2_edges_out_last", edges_out, 3);

    // T3: out-of-range IDs are dropped and counted, saturating at 255.
    send(11'd100); send(11'h7FF);
    idle_cycles(5);
    chk("t3_drop_cnt_2", drop_cnt, 2);
    chk("t3_busy_fifo_empty", busy, 0);
    chk("t3_no_issue", n_rdy, 4);
    for (int i = 0; i < 300; i++) begin
      send(11'(200 + i));
    end
    idle_cycles(3);
    chk("t3_drop_cnt_sat", drop_cnt, 255);
    chk("t3_no_issue_after_sat", n_rdy, 4);

    // T4: graph silent; fill the FIFO and let replies time out.
    reply_en = 1'b0;
    base = n_rdy;
    for (int i = 0; i < 9; i++) begin
      exp_id_q.push_back(11'(10 + i));
      send(11'(10 + i));
    end
    @(negedge clk);
    chk("t4_in_ready_full", in_ready, 0);
    chk("t4_busy", busy, 1);
    for (int k = 0; (k < 40) && (first_tmo_cyc < 0); k++) @(negedge clk);
    // data_rdy in cycle c, WAIT c+1..c+TIMEOUT, flag visible from c+TIMEOUT+1.
    chk("t4_timeout_delay", first_tmo_cyc - rdy_cyc_q[base], TB_TIMEOUT + 1);
    wait_rdy(base + 2, 40, "t4_next_issued");
    chk("t4_reissue_gap", rdy_cyc_q[base + 1] - rdy_cyc_q[base], TB_TIMEOUT + 2);

    // T5: reset while waiting with IDs 15..18 still buffered.
    wait_rdy(base + 5, 120, "t5_reach_4_buffered");
    chk("t5_in_ready_4_buffered", in_ready, 1);
    chk("t5_timeout_sticky", timeout_err, 1);
    idle_cycles(3);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_ID_out", ID_out, 0);
    chk("t5_data_rdy", data_rdy, 0);
    chk("t5_edges_out", edges_out, 0);
    chk("t5_edges_vld", edges_vld, 0);
    chk("t5_drop_cnt", drop_cnt, 0);
    chk("t5_timeout_err", timeout_err, 0);
    chk("t5_busy", busy, 0);
    exp_id_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(30);
    chk("t5_no_issue_after_rst", n_rdy, base + 5);
    chk("t5_busy_after_rst", busy, 0);

    // T6: highest legal ID.
    reply_en = 1'b1;
    base = n_rdy;
    exp_id_q.push_back(11'd99); rep_q.push_back(8'd7); exp_edges_q.push_back(8'd7);
    send(11'd99);
    wait_rdy(base + 1, 20, "t6_issued");
    idle_cycles(10);
    chk("t6_edges_out", edges_out, 7);
    chk("t6_no_timeout", timeout_err, 0);
    chk("t6_drop_cnt", drop_cnt, 0);

    // T7: repeated ID.
    base = n_rdy;
    exp_id_q.push_back(11'h002); rep_q.push_back(8'd11); exp_edges_q.push_back(8'd11);
`ifndef GRAPH_TX_DEDUP_EN
    exp_id_q.push_back(11'h002); rep_q.push_back(8'd12); exp_edges_q.push_back(8'd12);
`endif
    send(11'h002); send(11'h002);
    idle_cycles(40);
`ifdef GRAPH_TX_DEDUP_EN
    chk("t7_issue_count", n_rdy - base, 1);
    chk("t7_edges_out", edges_out, 11);
`else
    chk("t7_issue_count", n_rdy - base, 2);
    chk("t7_edges_out", edges_out, 12);
`endif
    chk("t7_busy", busy, 0);
    chk("t7_scoreboard_drained", exp_id_q.size() + exp_edges_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
